// File: rtl/regfile_sb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : regfile_sb_if                                          |
// | Description : Bundle of the decode/writeback signals that connect to |
// |               the scoreboarded register file.                        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface regfile_sb_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              enable;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              rsv;
  logic [ADDR_W-1:0] rsv_addr;
  logic              flush;
  logic              busy1;
  logic              busy2;
  logic              pend_any;

  // Control unit side: drives requests and addresses, observes operands and hazards.
  modport master (
    output enable, we, waddr, wdata, raddr1, raddr2, rsv, rsv_addr, flush,
    input  rdata1, rdata2, busy1, busy2, pend_any
  );

  // Register file side.
  modport slave (
    input  enable, we, waddr, wdata, raddr1, raddr2, rsv, rsv_addr, flush,
    output rdata1, rdata2, busy1, busy2, pend_any
  );
endinterface
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : regfile_sb                                             |
// | Description : Parametrised register file with optional write-to-read|
// |               bypass and a per-register pending-writeback scoreboard |
// |               for read-after-write hazard detection.                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module regfile_sb #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  wire logic   clk,
  input  wire logic   rst,   // asynchronous, active-low
  regfile_sb_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_pend;
  logic [DEPTH-1:0]  w_pend_next;

  logic w_wr;
  logic w_rsv;
  logic w_flush;
  logic w_hit1;
  logic w_hit2;

  // Writes and reservations aimed at register 0 are dropped when it is hardwired to zero.
  assign w_wr    = bus.enable && bus.we  && !((ZERO_REG != 0) && (bus.waddr    == '0));
  assign w_rsv   = bus.enable && bus.rsv && !((ZERO_REG != 0) && (bus.rsv_addr == '0));
  assign w_flush = bus.enable && bus.flush;

  // Write-hit terms used to clear busy in the writeback cycle (only meaningful with bypass).
  assign w_hit1 = (BYPASS != 0) && bus.enable && bus.we && (bus.waddr == bus.raddr1);
  assign w_hit2 = (BYPASS != 0) && bus.enable && bus.we && (bus.waddr == bus.raddr2);

  // Scoreboard update order: flush, then writeback clear, then reservation set (last wins).
  always_comb begin
    w_pend_next = r_pend;
    if (w_flush) w_pend_next = '0;
    if (w_wr)    w_pend_next[bus.waddr]    = 1'b0;
    if (w_rsv)   w_pend_next[bus.rsv_addr] = 1'b1;
  end

  // Register array storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[bus.waddr] <= bus.wdata;
    end
  end

  // Pending-writeback bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pend <= '0;
    else      r_pend <= w_pend_next;
  end

  // Combinational read for one port: stall, zero register, bypass, then array.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = '0;
    if (!bus.enable)                                  val = '0;
    else if ((ZERO_REG != 0) && (addr == '0))         val = '0;
    else if ((BYPASS != 0) && bus.we && (bus.waddr == addr)) val = bus.wdata;
    else                                              val = r_regs[addr];
    return val;
  endfunction

  // Read data ports.
  always_comb begin
    bus.rdata1 = read_port(bus.raddr1);
    bus.rdata2 = read_port(bus.raddr2);
  end

  // Hazard flags: pending and not being written back this cycle; register 0 never busy.
  always_comb begin
    bus.busy1 = r_pend[bus.raddr1] && !w_hit1 && !((ZERO_REG != 0) && (bus.raddr1 == '0));
    bus.busy2 = r_pend[bus.raddr2] && !w_hit2 && !((ZERO_REG != 0) && (bus.raddr2 == '0));
  end

  assign bus.pend_any = |r_pend;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_regfile_sb                                          |
// | Description : Directed self-checking bench for regfile_sb, with one  |
// |               bypassing and one non-bypassing instance side by side. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_regfile_sb;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  regfile_sb_if #(.DATA_W(8), .ADDR_W(3)) bus ();
  regfile_sb_if #(.DATA_W(8), .ADDR_W(3)) bus_nb ();

  // The non-bypassing instance sees exactly the same stimulus.
  assign bus_nb.enable   = bus.enable;
  assign bus_nb.we       = bus.we;
  assign bus_nb.waddr    = bus.waddr;
  assign bus_nb.wdata    = bus.wdata;
  assign bus_nb.raddr1   = bus.raddr1;
  assign bus_nb.raddr2   = bus.raddr2;
  assign bus_nb.rsv      = bus.rsv;
  assign bus_nb.rsv_addr = bus.rsv_addr;
  assign bus_nb.flush    = bus.flush;

  regfile_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  regfile_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk (clk),
    .rst (rst),
    .bus (bus_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports mismatches.
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.enable   = 1'b1;
    bus.we       = 1'b0;
    bus.waddr    = '0;
    bus.wdata    = '0;
    bus.raddr1   = '0;
    bus.raddr2   = '0;
    bus.rsv      = 1'b0;
    bus.rsv_addr = '0;
    bus.flush    = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    idle();

    // Reset held with random traffic.
    for (int i = 0; i < 4; i++) begin
      bus.enable   = 1'($urandom);
      bus.we       = 1'($urandom);
      bus.waddr    = 3'($urandom);
      bus.wdata    = 8'($urandom);
      bus.rsv      = 1'($urandom);
      bus.rsv_addr = 3'($urandom);
      bus.flush    = 1'($urandom);
      tick();
    end
    idle();
    bus.raddr1 = 3'd3;
    bus.raddr2 = 3'd5;
    #1;
    check("reset_rdata1", bus.rdata1, 0);
    check("reset_rdata2", bus.rdata2, 0);
    check("reset_busy1", bus.busy1, 0);
    check("reset_pend_any", bus.pend_any, 0);
    rst = 1'b1;
    tick();

    // Basic write then read every register.
    idle();
    bus.we = 1'b1; bus.waddr = 3'd3; bus.wdata = 8'hA5;
    tick();
    idle();
    for (int i = 0; i < 8; i++) begin
      bus.raddr1 = 3'(i);
      #1;
      check($sformatf("read_r%0d", i), bus.rdata1, (i == 3) ? 32'hA5 : 32'h0);
    end
    tick();

    // Zero register ignores writes and reservations.
    idle();
    bus.we = 1'b1; bus.waddr = 3'd0; bus.wdata = 8'hFF;
    bus.rsv = 1'b1; bus.rsv_addr = 3'd0;
    tick();
    idle();
    #1;
    check("zero_rdata1", bus.rdata1, 0);
    check("zero_busy1", bus.busy1, 0);
    check("zero_pend_any", bus.pend_any, 0);
    tick();

    // Same-cycle bypass vs. one-cycle latency without it.
    idle();
    bus.we = 1'b1; bus.waddr = 3'd5; bus.wdata = 8'h3C; bus.raddr2 = 3'd5;
    #1;
    check("bypass_rdata2", bus.rdata2, 32'h3C);
    check("nobypass_rdata2_old", bus_nb.rdata2, 0);
    tick();
    idle();
    bus.raddr2 = 3'd5;
    #1;
    check("bypass_rdata2_next", bus.rdata2, 32'h3C);
    check("nobypass_rdata2_next", bus_nb.rdata2, 32'h3C);
    tick();

    // Reserve r4: busy only from the following cycle.
    idle();
    bus.rsv = 1'b1; bus.rsv_addr = 3'd4; bus.raddr1 = 3'd4;
    #1;
    check("rsv_busy1_same_cycle", bus.busy1, 0);
    tick();
    idle();
    bus.raddr1 = 3'd4;
    #1;
    check("rsv_busy1", bus.busy1, 1);
    check("rsv_pend_any", bus.pend_any, 1);
    check("rsv_busy1_nb", bus_nb.busy1, 1);
    tick();

    // Writeback to r4 clears busy in the same cycle when bypassing.
    idle();
    bus.we = 1'b1; bus.waddr = 3'd4; bus.wdata = 8'h11; bus.raddr1 = 3'd4;
    #1;
    check("wb_busy1", bus.busy1, 0);
    check("wb_rdata1", bus.rdata1, 32'h11);
    check("wb_busy1_nb", bus_nb.busy1, 1);
    check("wb_rdata1_nb", bus_nb.rdata1, 0);
    check("wb_pend_any_same", bus.pend_any, 1);
    tick();
    idle();
    bus.raddr1 = 3'd4;
    #1;
    check("wb_pend_any_after", bus.pend_any, 0);
    check("wb_busy1_nb_after", bus_nb.busy1, 0);
    tick();

    // Write and reserve r6 together: data lands, pending stays set.
    idle();
    bus.we = 1'b1; bus.waddr = 3'd6; bus.wdata = 8'h77;
    bus.rsv = 1'b1; bus.rsv_addr = 3'd6;
    tick();
    idle();
    bus.raddr1 = 3'd6;
    #1;
    check("wr_rsv_rdata1", bus.rdata1, 32'h77);
    check("wr_rsv_busy1", bus.busy1, 1);
    tick();

    // Flush plus reserve r2: only r2 remains pending, data untouched.
    idle();
    bus.flush = 1'b1; bus.rsv = 1'b1; bus.rsv_addr = 3'd2;
    tick();
    idle();
    bus.raddr1 = 3'd6; bus.raddr2 = 3'd2;
    #1;
    check("flush_busy_r6", bus.busy1, 0);
    check("flush_busy_r2", bus.busy2, 1);
    check("flush_rdata_r6", bus.rdata1, 32'h77);
    check("flush_pend_any", bus.pend_any, 1);
    tick();

    // Write r1 and reserve r7 in the same cycle: both apply.
    idle();
    bus.we = 1'b1; bus.waddr = 3'd1; bus.wdata = 8'h5A;
    bus.rsv = 1'b1; bus.rsv_addr = 3'd7;
    tick();
    idle();
    bus.raddr1 = 3'd1; bus.raddr2 = 3'd7;
    #1;
    check("split_rdata_r1", bus.rdata1, 32'h5A);
    check("split_busy_r7", bus.busy2, 1);
    tick();

    // Stall: everything dropped, reads zero, busy still visible.
    idle();
    bus.enable = 1'b0;
    bus.we = 1'b1; bus.waddr = 3'd6; bus.wdata = 8'hEE;
    bus.rsv = 1'b1; bus.rsv_addr = 3'd3; bus.flush = 1'b1;
    bus.raddr1 = 3'd6; bus.raddr2 = 3'd2;
    #1;
    check("stall_rdata1", bus.rdata1, 0);
    check("stall_rdata2", bus.rdata2, 0);
    check("stall_busy2", bus.busy2, 1);
    tick();
    idle();
    bus.raddr1 = 3'd6; bus.raddr2 = 3'd3;
    #1;
    check("stall_kept_r6", bus.rdata1, 32'h77);
    check("stall_no_rsv_r3", bus.busy2, 0);
    bus.raddr2 = 3'd2;
    #1;
    check("stall_no_flush_r2", bus.busy2, 1);
    tick();

    // Reserve r1, then assert reset mid-cycle.
    idle();
    bus.rsv = 1'b1; bus.rsv_addr = 3'd1;
    tick();
    idle();
    bus.raddr1 = 3'd1; bus.raddr2 = 3'd6;
    #1;
    check("pre_rst_busy_r1", bus.busy1, 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_pend_any", bus.pend_any, 0);
    check("async_rst_busy_r1", bus.busy1, 0);
    check("async_rst_r1", bus.rdata1, 0);
    check("async_rst_r6", bus.rdata2, 0);
    // A write presented while reset is low must not land.
    bus.we = 1'b1; bus.waddr = 3'd3; bus.wdata = 8'h99;
    tick();
    idle();
    rst = 1'b1;
    bus.raddr1 = 3'd3;
    #1;
    check("rst_drop_write_r3", bus.rdata1, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
# regfile_sb

Parametrised successor to the 8×8 register file. It adds configurable width and depth, an optional same-cycle write-to-read bypass, and a per-register scoreboard of pending writebacks so the control unit can detect read-after-write hazards on multi-cycle (memory) results. It sits between decode and the ALU/memory writeback path, with `enable` driven by `mem_ready`, and keeps the zero-register convention.

## Interface
Parameters:
- `DATA_W`, 8, register width in bits.
- `ADDR_W`, 3, address width; DEPTH = 2**ADDR_W registers.
- `ZERO_REG`, 1, when 1, register 0 reads 0 and ignores writes and reservations.
- `BYPASS`, 1, when 1, a same-cycle write is forwarded to the read ports.

Ports:
- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-low. Clears all registers and pending bits.
- `enable` in 1: global qualifier. When 0, no state changes occur and `rdata1`/`rdata2` read 0.
- `we` in 1: write request.
- `waddr` in ADDR_W: write address.
- `wdata` in DATA_W: write data.
- `raddr1`, `raddr2` in ADDR_W: read addresses.
- `rdata1`, `rdata2` out DATA_W: combinational read data.
- `rsv` in 1: reserve destination. Marks `rsv_addr` as pending, meaning a result is outstanding.
- `rsv_addr` in ADDR_W: register to reserve.
- `flush` in 1: clears all pending bits. Data is kept.
- `busy1`, `busy2` out 1: operand at `raddr1`/`raddr2` is pending and not being written this cycle.
- `pend_any` out 1: at least one pending bit is set.

## Operation
- State: `regs[DEPTH]` of DATA_W bits and `pend[DEPTH]` of 1 bit.
- Write: when `enable && we` is true and the address is not zero-suppressed, `regs[waddr] <= wdata` and `pend[waddr] <= 0` at the clock edge.
- Reserve: when `enable && rsv` is true and the address is not zero-suppressed, `pend[rsv_addr] <= 1`.
- Write and reserve to the same address in the same cycle: data is written and pend ends at 1, because the new reservation wins.
- Write and reserve to different addresses in the same cycle: both take effect.
- Flush:
  - When `enable && flush` is true, all pend bits are cleared.
  - A reservation in the same cycle is still applied afterwards, so the reserved bit ends at 1.
  - Flush has no effect on `regs`.
- Read, per port k:
  - If `enable=0`, output 0.
  - Else if ZERO_REG and `raddr_k == 0`, output 0.
  - Else if BYPASS and `we && waddr == raddr_k`, output `wdata`.
  - Else output `regs[raddr_k]`.
- Busy, per port k:
  - `busy_k = pend[raddr_k] && !(enable && we && waddr == raddr_k)`.
  - When BYPASS=0, the write-hit term is omitted, so `busy_k = pend[raddr_k]`.
  - `busy_k` is forced to 0 for the zero register when ZERO_REG=1.
  - Busy is independent of `enable`, apart from the write-hit term.
- `pend_any` is the OR of all pend bits, taken from the registered state only.
- Addresses are always in range (DEPTH = 2**ADDR_W), so no bounds checks are needed.

## Timing
- Reset: asynchronous assertion; deassertion must be synchronous to `clk` at system level.
- Reset values: all `regs` = 0, all `pend` = 0, `busy1` = `busy2` = `pend_any` = 0, `rdata1` = `rdata2` = 0.
- Reset mid-operation: reservations in flight are lost, and no write completes on the edge where `rst` is low.
- Read latency: 0 cycles, combinational from the address inputs.
- Write-to-read latency:
  - 0 cycles with BYPASS=1.
  - 1 cycle with BYPASS=0; the old value is read in the write cycle.
- Reserve-to-busy latency: `busy` asserts on the cycle after `rsv` is sampled. In the reserve cycle itself, busy reflects the prior state.
- Writeback-to-not-busy latency:
  - 0 cycles with BYPASS=1; busy drops in the write cycle.
  - 1 cycle with BYPASS=0.
- `enable=0` stalls everything: writes, reservations and flush are dropped, not queued.
- No handshake on the write port: every qualified write completes in one cycle.

## Test plan
- Reset then basic write/read:
  - Hold `rst=0` with random inputs, then release.
  - Write 0xA5 to r3.
  - Next cycle, `raddr1=3` gives `rdata1=0xA5`. All other registers read 0.
- Zero register:
  - Write 0xFF to r0, and reserve r0.
  - `rdata1` with `raddr1=0` is 0, `busy1=0`, `pend_any=0`.
- Bypass (BYPASS=1): in one cycle, `we=1`, `waddr=5`, `wdata=0x3C`, `raddr2=5` gives `rdata2=0x3C` in the same cycle. With BYPASS=0, `rdata2` shows the old value until the next cycle.
- Scoreboard:
  - Reserve r4: `busy1` (with `raddr1=4`) is 1 from the next cycle and `pend_any=1`.
  - Write 0x11 to r4: `busy1=0` in the same cycle, `rdata1=0x11`, and `pend_any=0` the cycle after.
- Simultaneous write and reserve to r6: after the edge, r6=wdata and `busy` for r6 is 1. Flush plus reserve of r2 in one cycle leaves only r2 pending.
- Stall and async reset:
  - With `enable=0`, write/reserve/flush pulses cause no state change and read data is 0.
  - Assert `rst` low mid-cycle while r1 is pending: `pend_any` and all data clear immediately, without waiting for a clock edge.
